// File: rtl/logic_op_scheduler.sv
// logic_op_scheduler: round-robin sharing of one registered bitwise logic unit
// (AND/OR/XOR/NAND) between NUM_REQ requesters, with a valid/ready response.
// Optional feature: define LOGIC_OP_SCHED_STATS_EN to add the 16-bit saturating
// op_count output, which counts completed response handshakes.
module logic_op_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  input  logic [NUM_REQ*2-1:0]       req_op,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       busy,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [WIDTH-1:0]           rsp_data
`ifdef LOGIC_OP_SCHED_STATS_EN
  ,
  output logic [15:0]                op_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      ptr_q;
  logic [ID_W-1:0]      id_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [1:0]           op_q;
  logic [WIDTH-1:0]     rsp_data_q;
  logic [ID_W-1:0]      rsp_id_q;
  logic                 rsp_valid_q;

  logic                 win_found;
  logic [ID_W-1:0]      win_id;
  logic [NUM_REQ-1:0]   gnt_raw;
  logic                 grant_en;
  logic                 rsp_load;
  logic                 rsp_hs;

  // Opcode decode of the shared logic unit.
  function automatic logic [WIDTH-1:0] logic_op(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [1:0]       op);
    case (op)
      2'b00:   logic_op = a & b;
      2'b01:   logic_op = a | b;
      2'b10:   logic_op = a ^ b;
      default: logic_op = ~(a & b);
    endcase
  endfunction

  // Round-robin search: first set req bit at or above the pointer, wrapping.
  always_comb begin : winner_search
    int idx;
    // NOTE: every variable assigned in a combinational block gets a default
    // first; a path that leaves one unassigned infers a latch.
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  // FSM next state and per-state control strobes.
  always_comb begin
    state_d  = state_q;
    gnt_raw  = '0;
    grant_en = 1'b0;
    rsp_load = 1'b0;
    rsp_hs   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          gnt_raw[win_id] = 1'b1;
          grant_en        = 1'b1;
          state_d         = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_load = 1'b1;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_hs  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Operand capture on grant; the winner's ID travels with its operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      id_q <= '0;
    end else if (grant_en) begin
      a_q  <= req_a[win_id*WIDTH +: WIDTH];
      b_q  <= req_b[win_id*WIDTH +: WIDTH];
      op_q <= req_op[win_id*2 +: 2];
      id_q <= win_id;
    end
  end

  // Result register and response valid; data holds until the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else if (rsp_load) begin
      rsp_data_q  <= logic_op(a_q, b_q, op_q);
      rsp_id_q    <= id_q;
      rsp_valid_q <= 1'b1;
    end else if (rsp_hs) begin
      rsp_valid_q <= 1'b0;
    end
  end

  // Priority pointer moves past the winner only when its response is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (rsp_hs) begin
      if (id_q == ID_W'(NUM_REQ - 1)) ptr_q <= '0;
      else                            ptr_q <= id_q + ID_W'(1);
    end
  end

`ifdef LOGIC_OP_SCHED_STATS_EN
  logic [15:0] op_cnt_q;

  // Saturating count of response handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_q <= '0;
    end else if (rsp_hs && (op_cnt_q != 16'hFFFF)) begin
      op_cnt_q <= op_cnt_q + 16'd1;
    end
  end

  assign op_count = op_cnt_q;
`endif

  // Grant is masked by reset so every output reads zero while rst_n is low.
  assign gnt       = rst_n ? gnt_raw : '0;
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Directed testbench for logic_op_scheduler (NUM_REQ=4, WIDTH=8, ID_W=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// or 1 ns after it, away from the rising active edge.
module tb_logic_op_scheduler;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*2-1:0]     req_op;
  logic [NUM_REQ-1:0]       gnt;
  logic                     busy;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_data;
`ifdef LOGIC_OP_SCHED_STATS_EN
  logic [15:0]              op_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] op_exp [4] = '{8'h30, 8'hFC, 8'hCC, 8'hCF};

  logic_op_scheduler #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .ID_W    (ID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .gnt       (gnt),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
`ifdef LOGIC_OP_SCHED_STATS_EN
    ,
    .op_count  (op_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_opnd(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] op);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_op[i*2 +: 2]        = op;
  endtask

  // Called at a falling edge in IDLE with req already driven; walks one
  // transaction through EXEC and RESP (rsp_ready high) and returns at the
  // falling edge of the following IDLE cycle.
  task automatic issue(input logic [3:0] exp_gnt, input logic [1:0] exp_id,
                       input logic [7:0] exp_data, input bit drop);
    #1;
    check("idle_gnt", 32'(gnt), 32'(exp_gnt));
    check("idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    if (drop) req = req & ~exp_gnt;
    check("exec_gnt", 32'(gnt), 32'd0);
    check("exec_busy", 32'(busy), 32'd1);
    check("exec_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("resp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_id", 32'(rsp_id), 32'(exp_id));
    check("rsp_data", 32'(rsp_data), 32'(exp_data));
    check("resp_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    check("post_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_data", 32'(rsp_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester, all four opcodes: F0 op 3C
    for (int k = 0; k < 4; k++) begin
      set_opnd(0, 8'hF0, 8'h3C, 2'(k));
      req = 4'b0001;
      issue(4'b0001, 2'd0, op_exp[k], 1'b1);
    end

    // Round-robin from pointer 0 with all four held: 0,1,2,3,0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_opnd(i, 8'h10 + 8'(i), 8'hFF, 2'b00);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      issue(4'(1 << (k % 4)), 2'(k % 4), 8'h10 + 8'(k % 4), 1'b0);
    end
    req = 4'b0000;  // pointer now 1

    // Wrap and skip: grant 2 moves pointer to 3, then 0101 -> 0 first, then 2
    req = 4'b0100;
    issue(4'b0100, 2'd2, 8'h12, 1'b1);
    req = 4'b0101;
    issue(4'b0001, 2'd0, 8'h10, 1'b1);
    issue(4'b0100, 2'd2, 8'h12, 1'b1);  // pointer now 3

    // Backpressure: response held 10 cycles while requester 1 waits
    set_opnd(0, 8'hA5, 8'h0F, 2'b10);
    rsp_ready = 1'b0;
    req = 4'b0001;
    #1;
    check("bp_gnt0", 32'(gnt), 32'b0001);
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    check("bp_valid", 32'(rsp_valid), 32'd1);
    check("bp_data", 32'(rsp_data), 32'hAA);
    check("bp_id", 32'(rsp_id), 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_data", 32'(rsp_data), 32'hAA);
      check("bp_hold_gnt", 32'(gnt), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_gnt", 32'(gnt), 32'b0010);
    issue(4'b0010, 2'd1, 8'h11, 1'b1);  // pointer now 2

    // Reset during EXEC: op discarded, outputs zero, pointer back to 0
    req = 4'b0100;
    #1;
    check("mid_gnt", 32'(gnt), 32'b0100);
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_id", 32'(rsp_id), 32'd0);
    check("mid_rst_data", 32'(rsp_data), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    req = 4'b1010;  // pointer 0 picks 1; a stale pointer of 2 would pick 3
    rst_n = 1'b1;
    issue(4'b0010, 2'd1, 8'h11, 1'b1);
    issue(4'b1000, 2'd3, 8'h13, 1'b1);

`ifdef LOGIC_OP_SCHED_STATS_EN
    // Handshake counter: 5 counted, then saturation at FFFF
    rst_n = 1'b0;
    @(negedge clk);
    check("cnt_rst", 32'(op_count), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      req = 4'b0001;
      issue(4'b0001, 2'd0, 8'hAA, 1'b1);
    end
    check("cnt_five", 32'(op_count), 32'd5);
    force dut.op_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.op_cnt_q;
    check("cnt_forced", 32'(op_count), 32'hFFFE);
    for (int k = 0; k < 3; k++) begin
      req = 4'b0001;
      issue(4'b0001, 2'd0, 8'hAA, 1'b1);
    end
    check("cnt_sat", 32'(op_count), 32'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
